// File: rtl/crypt_pkg.sv
// rtl/crypt_pkg.sv - shared types and constants for the key scheduler and shift stages
package crypt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    typedef logic [1:0] key_idx_t;

    localparam logic [31:0] UPPER_LO = 32'd65;
    localparam logic [31:0] UPPER_HI = 32'd90;
    localparam logic [31:0] LOWER_LO = 32'd97;
    localparam logic [31:0] LOWER_HI = 32'd122;

    localparam key_idx_t KEY_K1 = 2'd0;
    localparam key_idx_t KEY_K2 = 2'd1;
    localparam key_idx_t KEY_K3 = 2'd2;

    // k1 -> k2 -> k3 -> k1; the illegal index 3 falls back to k1
    function automatic key_idx_t next_key(input key_idx_t k);
        case (k)
            KEY_K1:  next_key = KEY_K2;
            KEY_K2:  next_key = KEY_K3;
            default: next_key = KEY_K1;
        endcase
    endfunction

endpackage

// File: rtl/char_classify.sv
// rtl/char_classify.sv - combinational ASCII upper/lower case classifier
module char_classify
    import crypt_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] i_data,
    output logic              o_upper,
    output logic              o_lower
);

    logic [31:0] w_val;

    assign w_val   = 32'(i_data);
    assign o_upper = (w_val >= UPPER_LO) && (w_val <= UPPER_HI);
    assign o_lower = (w_val >= LOWER_LO) && (w_val <= LOWER_HI);

endmodule

// File: rtl/crypt_key_scheduler.sv
// rtl/crypt_key_scheduler.sv - key rotation and pipe-enable sequencing ahead of the shift stages
module crypt_key_scheduler
    import crypt_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ROT_W   = 3,
    parameter int SHIFT_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_load,
    input  logic [7:0]         cfg_k1,
    input  logic [7:0]         cfg_k2,
    input  logic [7:0]         cfg_k3,
    input  logic [ROT_W-1:0]   cfg_rot_freq,
    input  logic               cfg_mode,
    input  logic               stop,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_data,
    output logic               in_ready,
    output logic               en_out,
    output logic [DATA_W-1:0]  data_out,
    output logic               mode_out,
    output logic               shift_en,
    output logic [SHIFT_W-1:0] shift_amt,
    output logic               is_alpha_upper_case,
    output logic               is_alpha_low_case,
    output logic [1:0]         key_sel
);

    state_t           r_state;
    logic [7:0]       r_k1;
    logic [7:0]       r_k2;
    logic [7:0]       r_k3;
    logic [ROT_W-1:0] r_rot_freq;
    logic             r_mode;
    logic [ROT_W-1:0] r_cnt;
    key_idx_t         r_ptr;
    logic             r_in_ready;

    logic [7:0]         w_active_key;
    key_idx_t           w_ptr_eff;
    logic [SHIFT_W-1:0] w_shift_amt;
    logic               w_accept;
    logic               w_upper;
    logic               w_lower;
    logic               w_unused_key_bits;

    char_classify #(
        .DATA_W (DATA_W)
    ) u_classify (
        .i_data  (in_data),
        .o_upper (w_upper),
        .o_lower (w_lower)
    );

    // in_ready is a registered copy of "state is RUN", so accept needs no state decode
    assign w_accept          = in_valid && r_in_ready;
    assign w_ptr_eff         = (r_ptr == 2'd3) ? KEY_K1 : r_ptr;
    assign w_shift_amt       = w_active_key[SHIFT_W-1:0];
    assign w_unused_key_bits = ^w_active_key;
    assign in_ready          = r_in_ready;

    // active key mux; an out-of-range pointer reads as k1
    always_comb begin
        w_active_key = r_k1;
        case (r_ptr)
            KEY_K2:  w_active_key = r_k2;
            KEY_K3:  w_active_key = r_k3;
            default: w_active_key = r_k1;
        endcase
    end

    // sequencing FSM: config capture, restart, key rotation on each accept
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_k1       <= '0;
            r_k2       <= '0;
            r_k3       <= '0;
            r_rot_freq <= '0;
            r_mode     <= 1'b0;
            r_cnt      <= '0;
            r_ptr      <= KEY_K1;
            r_in_ready <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_in_ready <= 1'b0;
                    if (cfg_load) begin
                        r_k1       <= cfg_k1;
                        r_k2       <= cfg_k2;
                        r_k3       <= cfg_k3;
                        r_rot_freq <= cfg_rot_freq;
                        r_mode     <= cfg_mode;
                        r_state    <= LOAD;
                    end
                end
                LOAD: begin
                    r_cnt      <= '0;
                    r_ptr      <= KEY_K1;
                    r_in_ready <= 1'b1;
                    r_state    <= RUN;
                end
                RUN: begin
                    // rotation first; a following restart or stop makes it irrelevant
                    if (w_accept && (r_rot_freq != '0)) begin
                        if (r_cnt == (r_rot_freq - ROT_W'(1))) begin
                            r_cnt <= '0;
                            r_ptr <= next_key(r_ptr);
                        end else begin
                            r_cnt <= r_cnt + ROT_W'(1);
                        end
                    end else if (r_ptr == 2'd3) begin
                        r_ptr <= KEY_K1;
                    end
                    if (stop) begin
                        r_in_ready <= 1'b0;
                        r_state    <= IDLE;
                    end else if (cfg_load) begin
                        r_k1       <= cfg_k1;
                        r_k2       <= cfg_k2;
                        r_k3       <= cfg_k3;
                        r_rot_freq <= cfg_rot_freq;
                        r_mode     <= cfg_mode;
                        r_in_ready <= 1'b0;
                        r_state    <= LOAD;
                    end
                end
                default: begin
                    r_in_ready <= 1'b0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

    // output beat: one registered enable per accept, all other fields hold between beats
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_out              <= 1'b0;
            data_out            <= '0;
            mode_out            <= 1'b0;
            shift_en            <= 1'b0;
            shift_amt           <= '0;
            is_alpha_upper_case <= 1'b0;
            is_alpha_low_case   <= 1'b0;
            key_sel             <= 2'd0;
        end else begin
            en_out <= w_accept;
            if (w_accept) begin
                data_out            <= in_data;
                mode_out            <= r_mode;
                shift_amt           <= w_shift_amt;
                key_sel             <= w_ptr_eff;
                is_alpha_upper_case <= w_upper;
                is_alpha_low_case   <= w_lower;
                shift_en            <= (w_shift_amt != '0) && (w_upper || w_lower);
            end
        end
    end

endmodule

// File: tb/tb_crypt_key_scheduler.sv
// tb/tb_crypt_key_scheduler.sv - directed self-checking bench for crypt_key_scheduler
module tb_crypt_key_scheduler;

    logic       clk;
    logic       rst;
    logic       cfg_load;
    logic [7:0] cfg_k1;
    logic [7:0] cfg_k2;
    logic [7:0] cfg_k3;
    logic [2:0] cfg_rot_freq;
    logic       cfg_mode;
    logic       stop;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       en_out;
    logic [7:0] data_out;
    logic       mode_out;
    logic       shift_en;
    logic [2:0] shift_amt;
    logic       is_alpha_upper_case;
    logic       is_alpha_low_case;
    logic [1:0] key_sel;

    int checks   = 0;
    int failures = 0;

    int s1_data[7] = '{65, 66, 67, 68, 69, 70, 71};
    int s1_amt[7]  = '{3, 3, 5, 5, 1, 1, 3};
    int s1_ks[7]   = '{0, 0, 1, 1, 2, 2, 0};
    int s2_data[3] = '{97, 49, 122};
    int s2_lo[3]   = '{1, 0, 1};
    int s2_se[3]   = '{1, 0, 1};
    int s3_amt[4]  = '{0, 4, 7, 0};
    int s3_se[4]   = '{0, 1, 1, 0};
    int s3_ks[4]   = '{0, 1, 2, 0};

    crypt_key_scheduler #(
        .DATA_W  (8),
        .ROT_W   (3),
        .SHIFT_W (3)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .cfg_load            (cfg_load),
        .cfg_k1              (cfg_k1),
        .cfg_k2              (cfg_k2),
        .cfg_k3              (cfg_k3),
        .cfg_rot_freq        (cfg_rot_freq),
        .cfg_mode            (cfg_mode),
        .stop                (stop),
        .in_valid            (in_valid),
        .in_data             (in_data),
        .in_ready            (in_ready),
        .en_out              (en_out),
        .data_out            (data_out),
        .mode_out            (mode_out),
        .shift_en            (shift_en),
        .shift_amt           (shift_amt),
        .is_alpha_upper_case (is_alpha_upper_case),
        .is_alpha_low_case   (is_alpha_low_case),
        .key_sel             (key_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input int d, input int amt, input int ks,
                            input int se, input int up, input int lo, input int md);
        chk({tag, ".en"},    32'(en_out), 32'd1);
        chk({tag, ".data"},  32'(data_out), 32'(d));
        chk({tag, ".amt"},   32'(shift_amt), 32'(amt));
        chk({tag, ".ks"},    32'(key_sel), 32'(ks));
        chk({tag, ".sen"},   32'(shift_en), 32'(se));
        chk({tag, ".up"},    32'(is_alpha_upper_case), 32'(up));
        chk({tag, ".lo"},    32'(is_alpha_low_case), 32'(lo));
        chk({tag, ".mode"},  32'(mode_out), 32'(md));
    endtask

    task automatic load_cfg(input logic [7:0] k1, input logic [7:0] k2, input logic [7:0] k3,
                            input logic [2:0] rf, input logic md);
        cfg_k1       = k1;
        cfg_k2       = k2;
        cfg_k3       = k3;
        cfg_rot_freq = rf;
        cfg_mode     = md;
        cfg_load     = 1'b1;
        tick();
        cfg_load     = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; cfg_load = 1'b0; cfg_k1 = 8'h00; cfg_k2 = 8'h00; cfg_k3 = 8'h00;
        cfg_rot_freq = 3'd0; cfg_mode = 1'b0; stop = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        tick();
        tick();
        chk("rst.en", 32'(en_out), 32'd0);
        chk("rst.rdy", 32'(in_ready), 32'd0);
        chk("rst.data", 32'(data_out), 32'd0);
        chk("rst.amt", 32'(shift_amt), 32'd0);
        chk("rst.ks", 32'(key_sel), 32'd0);
        chk("rst.mode", 32'(mode_out), 32'd0);
        rst = 1'b1;
        tick();
        chk("idle.rdy", 32'(in_ready), 32'd0);

        // rot_freq 2 over "ABCDEFG", decrypt; cfg changes during RUN must be ignored
        load_cfg(8'h03, 8'h05, 8'h01, 3'd2, 1'b1);
        chk("t1.load_rdy", 32'(in_ready), 32'd0);
        tick();
        chk("t1.run_rdy", 32'(in_ready), 32'd1);
        cfg_k1 = 8'hFF; cfg_k2 = 8'hFF; cfg_k3 = 8'hFF; cfg_mode = 1'b0;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(s1_data[i]);
            tick();
            chk_beat($sformatf("t1[%0d]", i), s1_data[i], s1_amt[i], s1_ks[i], 1, 1, 0, 1);
        end
        in_valid = 1'b0;
        tick();
        chk("t1.idle_en", 32'(en_out), 32'd0);
        chk("t1.hold_data", 32'(data_out), 32'd71);

        // rot_freq 0: key frozen, non-alpha gets no shift
        load_cfg(8'h02, 8'h06, 8'h07, 3'd0, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(s2_data[i]);
            tick();
            chk_beat($sformatf("t2[%0d]", i), s2_data[i], 2, 0, s2_se[i], 0, s2_lo[i], 0);
        end
        in_valid = 1'b0;
        tick();

        // rot_freq 1: rotate on every character, zero key disables shift
        load_cfg(8'h00, 8'h04, 8'h07, 3'd1, 1'b0);
        tick();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 8'd77;
            tick();
            chk_beat($sformatf("t3[%0d]", i), 77, s3_amt[i], s3_ks[i], s3_se[i], 1, 0, 0);
        end
        in_valid = 1'b0;
        tick();

        // mid-stream restart after three characters
        load_cfg(8'h03, 8'h05, 8'h01, 3'd2, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(s1_data[i]);
            tick();
        end
        chk_beat("t4.pre", 67, 5, 1, 1, 1, 0, 0);
        in_data      = 8'd68;
        cfg_k1       = 8'h06;
        cfg_k2       = 8'h02;
        cfg_k3       = 8'h04;
        cfg_rot_freq = 3'd2;
        cfg_mode     = 1'b1;
        cfg_load     = 1'b1;
        tick();
        cfg_load     = 1'b0;
        chk_beat("t4.inflight", 68, 5, 1, 1, 1, 0, 0);
        chk("t4.load_rdy", 32'(in_ready), 32'd0);
        in_data = 8'd69;
        tick();
        chk("t4.load_en", 32'(en_out), 32'd0);
        chk("t4.load_hold", 32'(data_out), 32'd68);
        chk("t4.run_rdy", 32'(in_ready), 32'd1);
        tick();
        chk_beat("t4.new0", 69, 6, 0, 1, 1, 0, 1);
        in_data = 8'd70;
        tick();
        chk_beat("t4.new1", 70, 6, 0, 1, 1, 0, 1);
        in_data = 8'd71;
        tick();
        chk_beat("t4.new2", 71, 2, 1, 1, 1, 0, 1);
        in_valid = 1'b0;
        tick();

        // stop and cfg_load together: stop wins
        stop     = 1'b1;
        cfg_load = 1'b1;
        tick();
        stop     = 1'b0;
        cfg_load = 1'b0;
        chk("t5.rdy", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        in_data  = 8'd65;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("t5.en[%0d]", i), 32'(en_out), 32'd0);
            chk($sformatf("t5.rdy[%0d]", i), 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;

        // asynchronous reset while a beat is on the outputs
        load_cfg(8'h03, 8'h05, 8'h01, 3'd0, 1'b1);
        tick();
        in_valid = 1'b1;
        in_data  = 8'd65;
        tick();
        chk("t6.pre_en", 32'(en_out), 32'd1);
        in_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("t6.async_en", 32'(en_out), 32'd0);
        chk("t6.async_data", 32'(data_out), 32'd0);
        chk("t6.async_amt", 32'(shift_amt), 32'd0);
        chk("t6.async_mode", 32'(mode_out), 32'd0);
        rst = 1'b1;
        in_valid = 1'b1;
        tick();
        chk("t6.idle_rdy", 32'(in_ready), 32'd0);
        tick();
        chk("t6.idle_rdy2", 32'(in_ready), 32'd0);
        chk("t6.idle_en", 32'(en_out), 32'd0);
        in_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
